// File: rtl/apb_slave_regbank_if.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank_if
// Bus bundle between the AHB-to-APB bridge and one apb_slave_regbank.
//   Pselx      [2:0]  APB selects, one bit per slave instance
//   Penable           access-phase strobe
//   Pwrite            1 = write, 0 = read
//   Paddr      [31:0] byte address (only [5:2] is decoded by the slave)
//   Pwdata     [31:0] write data
//   Prdata     [31:0] read data from the slave
//   proto_err         sticky protocol-error flag from the slave
//   wr_count   [15:0] committed-write counter from the slave
//   rd_count   [15:0] committed-read counter from the slave
// ---------------------------------------------------------------------------
interface apb_slave_regbank_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        proto_err;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, proto_err, wr_count, rd_count
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, proto_err, wr_count, rd_count
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank
// APB slave register bank behind the AHB-to-APB bridge. Holds 14 RW data
// words, a status word {rd_count, wr_count} and a control word exposing the
// sticky protocol-error flag. Tracks the APB setup/access sequence and flags
// any out-of-order phase or a setup/access address or direction change.
//
// Parameters:
//   SLAVE_ID  which Pselx bit selects this instance (0..2)
// Ports:
//   Hclk      clock, rising edge
//   Hreset    synchronous active-high reset
//   apb       slave modport of apb_slave_regbank_if (Pselx, Penable, Pwrite,
//             Paddr, Pwdata in; Prdata, proto_err, wr_count, rd_count out)
// ---------------------------------------------------------------------------
module apb_slave_regbank #(
    parameter int SLAVE_ID = 0
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    apb_slave_regbank_if.slave    apb
);

    localparam int DATA_W = 32;
    localparam int NUM_RW = 14;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [3:0] IDX_STATUS = 4'd14;
    localparam logic [3:0] IDX_CTRL   = 4'd15;

    // state_q holds the phase of the previous bus cycle; the current cycle is
    // classified from it plus the live sel/Penable, so an access cycle is
    // recognised (and read data driven) while it is on the bus.
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [3:0]        cap_idx_q;
    logic              cap_wr_q;
    logic [DATA_W-1:0] regs_q [NUM_RW];
    logic [15:0]       wr_cnt_q;
    logic [15:0]       rd_cnt_q;
    logic              err_q;

    logic              sel;
    logic [3:0]        live_idx;
    logic              capture;
    logic              commit;
    logic              bad_phase;
    logic              mismatch;
    logic              set_err;
    logic              clr_err;
    logic [DATA_W-1:0] rdata;
    logic              unused_bits;

    assign sel         = apb.Pselx[SLAVE_ID];
    assign live_idx    = apb.Paddr[5:2];
    assign unused_bits = ^{apb.Paddr[31:6], apb.Paddr[1:0]};

    always_comb begin
        state_d   = ST_IDLE;
        capture   = 1'b0;
        commit    = 1'b0;
        bad_phase = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel && !apb.Penable) begin
                    state_d = ST_SETUP;
                    capture = 1'b1;
                end else if (sel) begin
                    bad_phase = 1'b1;
                end
            end
            ST_SETUP: begin
                if (sel && apb.Penable) begin
                    state_d = ST_ACCESS;
                    commit  = 1'b1;
                end else if (sel) begin
                    // repeated setup: flag it but restart from the new setup
                    state_d   = ST_SETUP;
                    capture   = 1'b1;
                    bad_phase = 1'b1;
                end else begin
                    bad_phase = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (sel && !apb.Penable) begin
                    state_d = ST_SETUP;
                    capture = 1'b1;
                end else if (sel) begin
                    bad_phase = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The transfer always commits with the setup-phase idx/direction even if
    // the live bus changed; the change only raises the error flag.
    assign mismatch = commit && ((live_idx != cap_idx_q) || (apb.Pwrite != cap_wr_q));
    assign set_err  = bad_phase || mismatch;
    assign clr_err  = commit && cap_wr_q && (cap_idx_q == IDX_CTRL) && apb.Pwdata[0];

    always_comb begin
        rdata = '0;
        if (commit && !cap_wr_q) begin
            case (cap_idx_q)
                IDX_STATUS: rdata = {rd_cnt_q, wr_cnt_q};
                IDX_CTRL:   rdata = {31'b0, err_q};
                default:    rdata = regs_q[cap_idx_q];
            endcase
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= ST_IDLE;
            cap_idx_q <= '0;
            cap_wr_q  <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cap_idx_q <= live_idx;
                cap_wr_q  <= apb.Pwrite;
            end
            if (commit && cap_wr_q)
                wr_cnt_q <= wr_cnt_q + 16'd1;
            if (commit && !cap_wr_q)
                rd_cnt_q <= rd_cnt_q + 16'd1;
            // a new error on the same edge as a clear wins
            if (set_err)
                err_q <= 1'b1;
            else if (clr_err)
                err_q <= 1'b0;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            for (int i = 0; i < NUM_RW; i++)
                regs_q[i] <= '0;
        end else if (commit && cap_wr_q && (cap_idx_q < IDX_STATUS)) begin
            regs_q[cap_idx_q] <= apb.Pwdata;
        end
    end

    assign apb.Prdata    = rdata;
    assign apb.proto_err = err_q;
    assign apb.wr_count  = wr_cnt_q;
    assign apb.rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
module tb_apb_slave_regbank;

    localparam logic [2:0] SEL = 3'b001;

    logic Hclk = 1'b0;
    logic Hreset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] q;

    apb_slave_regbank_if apb ();

    apb_slave_regbank #(.SLAVE_ID(0)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .apb    (apb.slave)
    );

    always #5 Hclk = ~Hclk;

    task automatic set_bus(input logic [2:0] s, input logic en, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        apb.Pselx   = s;
        apb.Penable = en;
        apb.Pwrite  = wr;
        apb.Paddr   = a;
        apb.Pwdata  = d;
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic idle();
        set_bus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        set_bus(SEL, 1'b0, 1'b1, a, d);
        step();
        set_bus(SEL, 1'b1, 1'b1, a, d);
        step();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] rd);
        set_bus(SEL, 1'b0, 1'b0, a, 32'h0);
        step();
        set_bus(SEL, 1'b1, 1'b0, a, 32'h0);
        #3;
        rd = apb.Prdata;
        step();
    endtask

    task automatic test_reset();
        Hreset = 1'b1;
        set_bus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        Hreset = 1'b0;
        #3;
        checks++; if (apb.wr_count !== 16'h0) begin errors++; $display("FAIL rst_wr: got %h want %h", apb.wr_count, 16'h0); end
        checks++; if (apb.rd_count !== 16'h0) begin errors++; $display("FAIL rst_rd: got %h want %h", apb.rd_count, 16'h0); end
        checks++; if (apb.proto_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want %b", apb.proto_err, 1'b0); end
        checks++; if (apb.Prdata !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h want %h", apb.Prdata, 32'h0); end
        step();
    endtask

    task automatic test_write_read();
        do_write(32'h8000_0008, 32'hDEAD_BEEF);
        do_read(32'h8000_0008, q);
        idle();
        checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_data: got %h want %h", q, 32'hDEAD_BEEF); end
        checks++; if (apb.wr_count !== 16'd1) begin errors++; $display("FAIL wr_rd_wr: got %h want %h", apb.wr_count, 16'd1); end
        checks++; if (apb.rd_count !== 16'd1) begin errors++; $display("FAIL wr_rd_rd: got %h want %h", apb.rd_count, 16'd1); end
        checks++; if (apb.proto_err !== 1'b0) begin errors++; $display("FAIL wr_rd_err: got %b want %b", apb.proto_err, 1'b0); end
        do_read(32'h0000_004B, q);
        idle();
        checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alias_data: got %h want %h", q, 32'hDEAD_BEEF); end
    endtask

    task automatic test_status();
        do_write(32'h0000_0038, 32'h0000_1234);
        do_read(32'h0000_0038, q);
        idle();
        checks++; if (q !== 32'h0002_0002) begin errors++; $display("FAIL status_data: got %h want %h", q, 32'h0002_0002); end
        checks++; if (apb.rd_count !== 16'd3) begin errors++; $display("FAIL status_rd: got %h want %h", apb.rd_count, 16'd3); end
        checks++; if (apb.wr_count !== 16'd2) begin errors++; $display("FAIL status_wr: got %h want %h", apb.wr_count, 16'd2); end
        do_read(32'h0000_0014, q);
        idle();
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL unwritten_reg: got %h want %h", q, 32'h0); end
    endtask

    task automatic test_proto_err();
        set_bus(SEL, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0055);
        #3;
        checks++; if (apb.Prdata !== 32'h0) begin errors++; $display("FAIL idle_en_prdata: got %h want %h", apb.Prdata, 32'h0); end
        step();
        checks++; if (apb.proto_err !== 1'b1) begin errors++; $display("FAIL idle_en_err: got %b want %b", apb.proto_err, 1'b1); end
        checks++; if (apb.wr_count !== 16'd2) begin errors++; $display("FAIL idle_en_wr: got %h want %h", apb.wr_count, 16'd2); end
        idle();
        do_write(32'h0000_003C, 32'h1);
        idle();
        checks++; if (apb.proto_err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b want %b", apb.proto_err, 1'b0); end
        checks++; if (apb.wr_count !== 16'd3) begin errors++; $display("FAIL clear_wr: got %h want %h", apb.wr_count, 16'd3); end
        // clear write whose access-phase address changed: error and clear on one edge
        set_bus(SEL, 1'b0, 1'b1, 32'h0000_003C, 32'h1);
        step();
        set_bus(SEL, 1'b1, 1'b1, 32'h0000_0000, 32'h1);
        step();
        checks++; if (apb.proto_err !== 1'b1) begin errors++; $display("FAIL clr_vs_err: got %b want %b", apb.proto_err, 1'b1); end
        checks++; if (apb.wr_count !== 16'd4) begin errors++; $display("FAIL clr_vs_err_wr: got %h want %h", apb.wr_count, 16'd4); end
        idle();
        do_write(32'h0000_003C, 32'h1);
        idle();
        checks++; if (apb.proto_err !== 1'b0) begin errors++; $display("FAIL clear2_err: got %b want %b", apb.proto_err, 1'b0); end
        // setup abandoned before access
        set_bus(SEL, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
        step();
        idle();
        checks++; if (apb.proto_err !== 1'b1) begin errors++; $display("FAIL setup_drop_err: got %b want %b", apb.proto_err, 1'b1); end
        checks++; if (apb.rd_count !== 16'd4) begin errors++; $display("FAIL setup_drop_rd: got %h want %h", apb.rd_count, 16'd4); end
        do_write(32'h0000_003C, 32'h1);
        idle();
        checks++; if (apb.wr_count !== 16'd6) begin errors++; $display("FAIL clear3_wr: got %h want %h", apb.wr_count, 16'd6); end
    endtask

    task automatic test_back_to_back();
        do_write(32'h0000_0000, 32'h0000_00A3);
        do_read(32'h0000_0000, q);
        idle();
        checks++; if (q !== 32'h0000_00A3) begin errors++; $display("FAIL b2b_data: got %h want %h", q, 32'h0000_00A3); end
        checks++; if (apb.proto_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want %b", apb.proto_err, 1'b0); end
        checks++; if (apb.wr_count !== 16'd7) begin errors++; $display("FAIL b2b_wr: got %h want %h", apb.wr_count, 16'd7); end
        checks++; if (apb.rd_count !== 16'd5) begin errors++; $display("FAIL b2b_rd: got %h want %h", apb.rd_count, 16'd5); end
        set_bus(3'b010, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        set_bus(3'b010, 1'b1, 1'b0, 32'h0, 32'h0);
        #3;
        checks++; if (apb.Prdata !== 32'h0) begin errors++; $display("FAIL other_sel_prdata: got %h want %h", apb.Prdata, 32'h0); end
        step();
        idle();
        checks++; if (apb.rd_count !== 16'd5) begin errors++; $display("FAIL other_sel_rd: got %h want %h", apb.rd_count, 16'd5); end
        checks++; if (apb.proto_err !== 1'b0) begin errors++; $display("FAIL other_sel_err: got %b want %b", apb.proto_err, 1'b0); end
    endtask

    task automatic test_reset_mid();
        set_bus(SEL, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0077);
        Hreset = 1'b1;
        step();
        Hreset = 1'b0;
        set_bus(SEL, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0077);
        #3;
        checks++; if (apb.Prdata !== 32'h0) begin errors++; $display("FAIL rst_mid_prdata: got %h want %h", apb.Prdata, 32'h0); end
        step();
        checks++; if (apb.proto_err !== 1'b1) begin errors++; $display("FAIL rst_mid_err: got %b want %b", apb.proto_err, 1'b1); end
        checks++; if (apb.wr_count !== 16'd0) begin errors++; $display("FAIL rst_mid_wr: got %h want %h", apb.wr_count, 16'd0); end
        checks++; if (apb.rd_count !== 16'd0) begin errors++; $display("FAIL rst_mid_rd: got %h want %h", apb.rd_count, 16'd0); end
        idle();
        do_read(32'h0000_0010, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_mid_reg4: got %h want %h", q, 32'h0); end
        do_read(32'h0000_0000, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_mid_reg0: got %h want %h", q, 32'h0); end
        do_write(32'h0000_003C, 32'h1);
        idle();
        checks++; if (apb.proto_err !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: got %b want %b", apb.proto_err, 1'b0); end
        checks++; if (apb.wr_count !== 16'd1) begin errors++; $display("FAIL rst_mid_wr2: got %h want %h", apb.wr_count, 16'd1); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 65534; i++)
            do_write(32'h0000_0018, i);
        idle();
        checks++; if (apb.wr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h want %h", apb.wr_count, 16'hFFFF); end
        do_write(32'h0000_0018, 32'hCAFE_F00D);
        idle();
        checks++; if (apb.wr_count !== 16'h0000) begin errors++; $display("FAIL wrap_post: got %h want %h", apb.wr_count, 16'h0000); end
        do_read(32'h0000_0018, q);
        idle();
        checks++; if (q !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_data: got %h want %h", q, 32'hCAFE_F00D); end
        checks++; if (apb.proto_err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want %b", apb.proto_err, 1'b0); end
    endtask

    initial begin
        Hreset = 1'b1;
        set_bus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_write_read();
        test_status();
        test_proto_err();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

APB slave register bank that sits directly downstream of the AHB-to-APB bridge, on one of its three `Pselx` lines. It accepts the bridge's two-phase APB transfers (setup, then access), holds 14 read/write data words, and keeps write/read transfer counters. It tracks the APB phase sequence with a small state machine and flags any protocol violation in a sticky error bit. Three instances, one per `SLAVE_ID`, form the peripheral side of the bridge bench.

## Interface
Parameters:
- `SLAVE_ID`, default 0: which `Pselx` bit selects this instance; legal values 0..2.

Ports:
- `Hclk`  in  1  single clock; all state updates on its rising edge.
- `Hreset`  in  1  synchronous, active-high reset, sampled on `Hclk` rising edge.
- `Pselx`  in  3  APB selects; this instance responds only to `Pselx[SLAVE_ID]`, called `sel` below.
- `Penable`  in  1  APB access-phase strobe.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  32  address; only `Paddr[5:2]` is decoded, giving the register index `idx`.
- `Pwdata`  in  32  write data; sampled in the access cycle.
- `Prdata`  out  32  read data, combinational.
- `proto_err`  out  1  sticky protocol-error flag.
- `wr_count`  out  16  count of committed writes.
- `rd_count`  out  16  count of committed reads.

## Operation
Register map, indexed by `idx`:
- 0..13: RW data words.
- 14: RO status, read value `{rd_count, wr_count}`; writes to it are ignored but still counted.
- 15: control. Read value is `{31'b0, proto_err}`. A write with `Pwdata[0]=1` clears `proto_err`; other bits are ignored.

Aliasing:
- `Paddr[31:6]` and `Paddr[1:0]` are ignored, so addresses alias every 64 bytes.

Phase FSM:
- States are IDLE, SETUP, ACCESS; the state is registered.
- IDLE: `sel & ~Penable` → SETUP; `sel & Penable` → error, stay IDLE; `~sel` → IDLE.
- SETUP: captures `idx` and `Pwrite` at entry.
  - `sel & Penable` → ACCESS.
  - `sel & ~Penable` → error, recapture, stay SETUP.
  - `~sel` → error, IDLE.
- ACCESS (always exactly one cycle, no wait states):
  - The transfer commits at the closing edge of the ACCESS cycle.
  - `sel & ~Penable` → SETUP (back-to-back transfer).
  - `~sel` → IDLE.
  - `sel & Penable` → error, IDLE.
- Commit rules:
  - The transfer uses the captured `idx`/`Pwrite`.
  - If live `Paddr[5:2]` or `Pwrite` differs from the captured value during ACCESS, flag an error but still commit with the captured values.
  - Write commit: for `idx` 0..13, `reg[idx] <= Pwdata`; then `wr_count++`.
  - Read commit: `rd_count++`.
- `Prdata` value:
  - `Prdata = rdval(captured idx)` when the state is ACCESS, `sel & Penable`, and the captured `Pwrite` is 0.
  - Otherwise `Prdata = 0`.
- Counters wrap from 0xFFFF to 0x0000.
- `proto_err`:
  - Set at the edge after any error condition.
  - Cleared by a committed write of 1 to `idx` 15.
  - If a clear and a new error land on the same edge, the error wins and `proto_err` stays 1.

## Timing
- Reset: on `Hreset=1` at a rising edge, the following all clear to 0 and the FSM goes to IDLE:
  - all data registers, `proto_err`, `wr_count`, `rd_count`;
  - the captured `idx`/`Pwrite`.
- Reset mid-operation: an in-flight transfer is discarded with no register write and no count increment.
- `Prdata` has zero latency: it is valid in the same ACCESS cycle, combinationally from the registers. It reads 0 in the cycle after reset.
- Write-to-read: data written in ACCESS cycle N is readable in any ACCESS cycle > N.
- Reading `idx` 14 returns the pre-increment counts; the read's own increment is visible from the next cycle.
- A minimum transfer is 2 cycles (SETUP, ACCESS). Back-to-back transfers are sustainable at 2 cycles each with no IDLE in between.
- `proto_err`, `wr_count` and `rd_count` are registered: each updates one edge after its causing cycle.
- Any cycle with `sel=0`, or in a non-ACCESS state, has no effect except as listed in the FSM rules above.

## Test plan
- Reset, then write 0xDEADBEEF to `Paddr` 0x8000_0008 (`idx` 2, SLAVE_ID 0), then read it back → `Prdata`=0xDEADBEEF in the read ACCESS cycle; `wr_count`=1, `rd_count`=1; `proto_err`=0.
- Write `idx` 14 with 0x1234, then read `idx` 14 → the write is ignored; read returns 0x0000_0001 (rd 0, wr 1); afterwards `rd_count`=1.
- Assert `Penable` with `sel` while in IDLE → no commit, `proto_err`=1 next cycle. Then write 1 to `idx` 15 → `proto_err`=0. Then fire a clear write and an error on the same edge → `proto_err` stays 1.
- Preload `wr_count`=0xFFFF via 65535 writes, then one more write → `wr_count`=0x0000.
- Run back-to-back SETUP/ACCESS pairs (write `idx` 0=0xA3, then read `idx` 0) with no IDLE in between → read returns 0xA3 and `proto_err`=0. Also drive `Pselx`=3'b010 toward SLAVE_ID 0 → no response and `Prdata`=0.
- Assert `Hreset` during the SETUP of a write → after reset, `reg[idx]`=0, `wr_count`=0, FSM in IDLE; the following ACCESS-looking cycle (`sel & Penable`) flags `proto_err`.
